// File: rtl/move_decider.sv
// move_decider: sequences goal check, memory read, eight direction
// evaluations and a priority-ordered argmax to choose one move per turn.
module move_decider #(
    parameter int          SCORE_W      = 8,
    parameter int          COORD_W      = 8,
    parameter int          EVAL_TIMEOUT = 1023,
    // 3 bits per slot, slot 0 in bits [2:0]; red order 4,3,5,2,6,1,7,0
    parameter logic [23:0] PRIO_RED     = 24'o07162534,
    // blue order 0,1,7,2,6,3,5,4
    parameter logic [23:0] PRIO_BLUE    = 24'o45362710
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               my_turn,
    input  logic [COORD_W-1:0] cur_x_in,
    input  logic [COORD_W-1:0] cur_y_in,
    input  logic [COORD_W-1:0] width_in,
    input  logic [COORD_W-1:0] length_in,
    input  logic               color_in,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic [COORD_W-1:0] width,
    output logic [COORD_W-1:0] length,
    output logic               color,
    input  logic               mem_idle,
    input  logic               mem_finish,
    output logic               mem_start,
    input  logic               eval_idle,
    input  logic               eval_done,
    input  logic               eval_noperm,
    input  logic [SCORE_W-1:0] eval_score,
    input  logic               eval_extra,
    output logic               eval_start,
    output logic [2:0]         eval_dir,
    output logic               idle,
    output logic [2:0]         direction,
    output logic               extra_move,
    output logic               no_move,
    output logic               direction_valid
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_CHECK     = 4'd1;
    localparam logic [3:0] S_MEM_WAIT  = 4'd2;
    localparam logic [3:0] S_MEM_RD    = 4'd3;
    localparam logic [3:0] S_EVAL_WAIT = 4'd4;
    localparam logic [3:0] S_EVAL      = 4'd5;
    localparam logic [3:0] S_NEXT      = 4'd6;
    localparam logic [3:0] S_DECIDE    = 4'd7;
    localparam logic [3:0] S_RESULT    = 4'd8;

    localparam int TO_W = (EVAL_TIMEOUT > 0) ? $clog2(EVAL_TIMEOUT + 1) : 1;

    logic [3:0]                 state_q, state_d;
    logic [2:0]                 k_q, k_d;
    logic [TO_W-1:0]            to_q, to_d;
    logic [COORD_W-1:0]         cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [COORD_W-1:0]         width_q, width_d, length_q, length_d;
    logic                       color_q, color_d;
    logic                       mem_start_q, mem_start_d;
    logic                       eval_start_q, eval_start_d;
    logic [2:0]                 eval_dir_q, eval_dir_d;
    logic [2:0]                 dir_q, dir_d;
    logic                       extra_q, extra_d;
    logic                       nomove_q, nomove_d;
    logic [7:0][SCORE_W-1:0]    score_q, score_d;
    logic [7:0]                 legal_q, legal_d;
    logic [7:0]                 xtra_q, xtra_d;
    logic                       best_vld_q, best_vld_d;
    logic [2:0]                 best_dir_q, best_dir_d;
    logic [SCORE_W-1:0]         best_score_q, best_score_d;

    logic [COORD_W-1:0]         half, half_m1, half_p1;
    logic                       goal_hit;
    logic [2:0]                 goal_dir;
    logic [7:0][2:0]            prio;
    logic [2:0]                 cand;
    logic                       take;
    logic [2:0]                 final_dir;
    logic                       timed_out;

    // Goal shortcut: ball sits on the opponent goal line within one of centre.
    always_comb begin
        half     = width_q >> 1;
        half_m1  = half - COORD_W'(1);
        half_p1  = half + COORD_W'(1);
        goal_hit = 1'b0;
        goal_dir = 3'd0;
        if (color_q ? (cur_y_q == '0) : (cur_y_q == length_q)) begin
            if (cur_x_q == half_m1) begin
                goal_hit = 1'b1;
                goal_dir = color_q ? 3'd3 : 3'd1;
            end else if (cur_x_q == half) begin
                goal_hit = 1'b1;
                goal_dir = color_q ? 3'd4 : 3'd0;
            end else if (cur_x_q == half_p1) begin
                goal_hit = 1'b1;
                goal_dir = color_q ? 3'd5 : 3'd7;
            end
        end
    end

    // Argmax step: candidate for this scan slot and whether it displaces the best.
    always_comb begin
        prio      = color_q ? PRIO_RED : PRIO_BLUE;
        cand      = prio[k_q];
        take      = legal_q[cand] && (!best_vld_q || (score_q[cand] > best_score_q));
        final_dir = take ? cand : best_dir_q;
        timed_out = (EVAL_TIMEOUT != 0) && (to_q == TO_W'(EVAL_TIMEOUT));
    end

    // Next-state and datapath update for the turn sequencer.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        to_d         = to_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        width_d      = width_q;
        length_d     = length_q;
        color_d      = color_q;
        mem_start_d  = mem_start_q;
        eval_start_d = eval_start_q;
        eval_dir_d   = eval_dir_q;
        dir_d        = dir_q;
        extra_d      = extra_q;
        nomove_d     = nomove_q;
        score_d      = score_q;
        legal_d      = legal_q;
        xtra_d       = xtra_q;
        best_vld_d   = best_vld_q;
        best_dir_d   = best_dir_q;
        best_score_d = best_score_q;
        case (state_q)
            S_IDLE: begin
                if (my_turn) begin
                    cur_x_d  = cur_x_in;
                    cur_y_d  = cur_y_in;
                    width_d  = width_in;
                    length_d = length_in;
                    color_d  = color_in;
                    extra_d  = 1'b0;
                    nomove_d = 1'b0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (goal_hit) begin
                    dir_d   = goal_dir;
                    state_d = S_RESULT;
                end else begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (mem_idle) begin
                    mem_start_d = 1'b1;
                    state_d     = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_finish) begin
                    mem_start_d = 1'b0;
                    k_d         = 3'd0;
                    // Fresh slate each turn so nothing from a prior turn is scanned.
                    score_d     = '0;
                    legal_d     = '0;
                    xtra_d      = '0;
                    state_d     = S_EVAL_WAIT;
                end
            end
            S_EVAL_WAIT: begin
                if (eval_idle) begin
                    eval_start_d = 1'b1;
                    eval_dir_d   = k_q;
                    to_d         = '0;
                    state_d      = S_EVAL;
                end
            end
            S_EVAL: begin
                // A timeout or refusal outranks a result arriving in the same cycle.
                if (eval_noperm || timed_out) begin
                    legal_d[k_q] = 1'b0;
                    eval_start_d = 1'b0;
                    state_d      = S_NEXT;
                end else if (eval_done) begin
                    legal_d[k_q] = 1'b1;
                    score_d[k_q] = eval_score;
                    xtra_d[k_q]  = eval_extra;
                    eval_start_d = 1'b0;
                    state_d      = S_NEXT;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_NEXT: begin
                if (k_q == 3'd7) begin
                    k_d          = 3'd0;
                    best_vld_d   = 1'b0;
                    best_dir_d   = 3'd0;
                    best_score_d = '0;
                    state_d      = S_DECIDE;
                end else begin
                    k_d     = k_q + 3'd1;
                    state_d = S_EVAL_WAIT;
                end
            end
            S_DECIDE: begin
                if (take) begin
                    best_vld_d   = 1'b1;
                    best_dir_d   = cand;
                    best_score_d = score_q[cand];
                end
                if (k_q == 3'd7) begin
                    if (take || best_vld_q) begin
                        dir_d    = final_dir;
                        extra_d  = xtra_q[final_dir];
                        nomove_d = 1'b0;
                    end else begin
                        dir_d    = 3'd1;
                        extra_d  = 1'b0;
                        nomove_d = 1'b1;
                    end
                    k_d     = 3'd0;
                    state_d = S_RESULT;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_RESULT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            k_q          <= 3'd0;
            to_q         <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            width_q      <= '0;
            length_q     <= '0;
            color_q      <= 1'b0;
            mem_start_q  <= 1'b0;
            eval_start_q <= 1'b0;
            eval_dir_q   <= 3'd0;
            dir_q        <= 3'd0;
            extra_q      <= 1'b0;
            nomove_q     <= 1'b0;
            score_q      <= '0;
            legal_q      <= '0;
            xtra_q       <= '0;
            best_vld_q   <= 1'b0;
            best_dir_q   <= 3'd0;
            best_score_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            to_q         <= to_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            width_q      <= width_d;
            length_q     <= length_d;
            color_q      <= color_d;
            mem_start_q  <= mem_start_d;
            eval_start_q <= eval_start_d;
            eval_dir_q   <= eval_dir_d;
            dir_q        <= dir_d;
            extra_q      <= extra_d;
            nomove_q     <= nomove_d;
            score_q      <= score_d;
            legal_q      <= legal_d;
            xtra_q       <= xtra_d;
            best_vld_q   <= best_vld_d;
            best_dir_q   <= best_dir_d;
            best_score_q <= best_score_d;
        end
    end

    assign cur_x           = cur_x_q;
    assign cur_y           = cur_y_q;
    assign width           = width_q;
    assign length          = length_q;
    assign color           = color_q;
    assign mem_start       = mem_start_q;
    assign eval_start      = eval_start_q;
    assign eval_dir        = eval_dir_q;
    assign idle            = (state_q == S_IDLE);
    assign direction       = dir_q;
    assign extra_move      = extra_q;
    assign no_move         = nomove_q;
    assign direction_valid = (state_q == S_RESULT);

endmodule

// File: tb/tb_move_decider.sv
// Bench for move_decider: emulated memory/evaluator, turn-level model, per-cycle checker.
module tb_move_decider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       my_turn = 1'b0;
    logic [7:0] cur_x_in = '0, cur_y_in = '0, width_in = '0, length_in = '0;
    logic       color_in = 1'b0;
    logic [7:0] cur_x, cur_y, width, length;
    logic       color;
    logic       mem_idle, mem_finish, mem_start;
    logic       eval_idle, eval_done, eval_noperm, eval_extra, eval_start;
    logic [7:0] eval_score;
    logic [2:0] eval_dir, direction;
    logic       idle, extra_move, no_move, direction_valid;

    always #5 clk = ~clk;

    move_decider #(.SCORE_W(8), .COORD_W(8), .EVAL_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .my_turn(my_turn),
        .cur_x_in(cur_x_in), .cur_y_in(cur_y_in), .width_in(width_in), .length_in(length_in),
        .color_in(color_in), .cur_x(cur_x), .cur_y(cur_y), .width(width), .length(length),
        .color(color), .mem_idle(mem_idle), .mem_finish(mem_finish), .mem_start(mem_start),
        .eval_idle(eval_idle), .eval_done(eval_done), .eval_noperm(eval_noperm),
        .eval_score(eval_score), .eval_extra(eval_extra), .eval_start(eval_start),
        .eval_dir(eval_dir), .idle(idle), .direction(direction), .extra_move(extra_move),
        .no_move(no_move), .direction_valid(direction_valid)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Evaluator behaviour per direction: 0 done, 1 noperm, 2 silent, 3 done+noperm
    int beh[8];
    int dly[8];
    int sc[8];
    int ex[8];
    int cfg_color, cfg_x, cfg_y, cfg_w, cfg_l;
    int exp_dir, exp_extra, exp_nomove;
    bit exp_goal;
    int results = 0;
    int red_ord[8]  = '{4, 3, 5, 2, 6, 1, 7, 0};
    int blue_ord[8] = '{0, 1, 7, 2, 6, 3, 5, 4};

    // Cycles eval_start stays high for direction d under timeout 4.
    function automatic int exp_len(input int d);
        if (beh[d] == 2 || dly[d] >= 4) return 5;
        return dly[d] + 1;
    endfunction

    // Turn outcome from the rules: goal shortcut, else first-best in priority order.
    task automatic model();
        int half, best, bs, d;
        half = cfg_w / 2;
        exp_goal = 0;
        exp_extra = 0;
        exp_nomove = 0;
        if ((cfg_color == 0 && cfg_y == cfg_l) || (cfg_color == 1 && cfg_y == 0)) begin
            if (cfg_x == half - 1)      begin exp_goal = 1; exp_dir = cfg_color ? 3 : 1; end
            else if (cfg_x == half)     begin exp_goal = 1; exp_dir = cfg_color ? 4 : 0; end
            else if (cfg_x == half + 1) begin exp_goal = 1; exp_dir = cfg_color ? 5 : 7; end
        end
        if (!exp_goal) begin
            best = -1;
            bs = 0;
            for (int i = 0; i < 8; i++) begin
                d = cfg_color ? red_ord[i] : blue_ord[i];
                if (beh[d] == 0 && dly[d] <= 3 && (best < 0 || sc[d] > bs)) begin
                    best = d;
                    bs = sc[d];
                end
            end
            if (best < 0) begin exp_dir = 1; exp_extra = 0; exp_nomove = 1; end
            else          begin exp_dir = best; exp_extra = ex[best]; end
        end
    endtask

    // Memory reader: idle most cycles, finishes two cycles after a request.
    initial begin : mem_rsp
        int cnt, c;
        bit served;
        cnt = 0; c = 0; served = 0;
        mem_idle = 1'b1;
        mem_finish = 1'b0;
        forever begin
            @(negedge clk);
            c++;
            mem_finish = 1'b0;
            mem_idle = (c % 4 != 1);
            if (!mem_start) begin
                served = 0;
                cnt = 0;
            end else if (!served) begin
                if (cnt == 2) begin mem_finish = 1'b1; served = 1; end
                else cnt++;
            end
        end
    end

    // Evaluator: answers per beh/dly, then reports busy for two cycles.
    initial begin : eval_rsp
        int cnt, busy, d;
        bit served;
        cnt = 0; busy = 0; served = 0;
        eval_idle = 1'b1; eval_done = 1'b0; eval_noperm = 1'b0;
        eval_score = '0; eval_extra = 1'b0;
        forever begin
            @(negedge clk);
            eval_done = 1'b0; eval_noperm = 1'b0; eval_score = '0; eval_extra = 1'b0;
            if (!eval_start) begin
                if (served) busy = 2;
                served = 0;
                cnt = 0;
            end else if (!served) begin
                d = int'(eval_dir);
                if (cnt == dly[d]) begin
                    served = 1;
                    eval_score = 8'(sc[d]);
                    eval_extra = ex[d][0];
                    eval_done = (beh[d] == 0 || beh[d] == 3);
                    eval_noperm = (beh[d] == 1 || beh[d] == 3);
                end else cnt++;
            end
            if (busy > 0) begin eval_idle = 1'b0; busy--; end
            else eval_idle = 1'b1;
        end
    end

    // Per-cycle checker against the turn model.
    initial begin : cmp
        bit pending, going_idle, hold, prev_es, prev_dv;
        int cyc, acc_cyc, fall7, k_exp, run, run_dir, h_dir, h_ex, h_nm;
        pending = 0; going_idle = 0; hold = 0; prev_es = 0; prev_dv = 0;
        cyc = 0; acc_cyc = 0; fall7 = -100; k_exp = 0; run = 0; run_dir = 0;
        h_dir = 0; h_ex = 0; h_nm = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                chk("rst_idle", idle, 1);
                chk("rst_mem_start", mem_start, 0);
                chk("rst_eval_start", eval_start, 0);
                chk("rst_dv", direction_valid, 0);
                pending = 0; going_idle = 0; hold = 1; prev_es = 0; prev_dv = 0;
                h_dir = 0; h_ex = 0; h_nm = 0;
            end else begin
                if (going_idle) begin
                    pending = 0;
                    going_idle = 0;
                end else if (!pending && my_turn) begin
                    pending = 1; acc_cyc = cyc; hold = 0; k_exp = 0; fall7 = -100;
                end
                chk("idle", idle, !pending);
                if (eval_start && !prev_es) begin
                    chk("eval_dir", eval_dir, k_exp);
                    run_dir = int'(eval_dir);
                    k_exp++;
                    run = 0;
                end
                if (eval_start) run++;
                if (!eval_start && prev_es) begin
                    chk("eval_len", run, exp_len(run_dir));
                    if (run_dir == 7) fall7 = cyc;
                end
                prev_es = eval_start;
                if (pending && exp_goal) chk("goal_no_mem", mem_start, 0);
                if (direction_valid) begin
                    chk("dv_in_turn", pending, 1);
                    chk("dv_single", prev_dv, 0);
                    chk("direction", direction, exp_dir);
                    chk("extra_move", extra_move, exp_extra);
                    chk("no_move", no_move, exp_nomove);
                    if (exp_goal) chk("goal_latency", cyc - acc_cyc, 1);
                    else begin
                        chk("decide_latency", cyc - fall7, 9);
                        chk("eval_count", k_exp, 8);
                    end
                    h_dir = exp_dir; h_ex = exp_extra; h_nm = exp_nomove;
                    hold = 1;
                    going_idle = 1;
                    results++;
                end else if (hold) begin
                    chk("hold_dir", direction, h_dir);
                    chk("hold_extra", extra_move, h_ex);
                    chk("hold_nomove", no_move, h_nm);
                end
                prev_dv = direction_valid;
            end
        end
    end

    task automatic clr_cfg();
        for (int i = 0; i < 8; i++) begin
            beh[i] = 0; dly[i] = i % 4; sc[i] = 0; ex[i] = 0;
        end
    endtask

    // One turn; lit_* are hand-derived expectations for this vector.
    task automatic turn(input int col, input int x, input int y, input int w, input int l,
                        input int lit_dir, input int lit_ex, input int lit_nm, input bit poke);
        int r0, t;
        cfg_color = col; cfg_x = x; cfg_y = y; cfg_w = w; cfg_l = l;
        model();
        @(negedge clk);
        t = 0;
        while (!idle && t < 50) begin @(negedge clk); t++; end
        r0 = results;
        color_in = col[0]; cur_x_in = 8'(x); cur_y_in = 8'(y);
        width_in = 8'(w); length_in = 8'(l);
        my_turn = 1'b1;
        @(negedge clk);
        my_turn = 1'b0;
        if (poke) begin
            repeat (2) @(negedge clk);
            my_turn = 1'b1; color_in = ~col[0]; cur_x_in = 8'(x + 1);
            @(negedge clk);
            my_turn = 1'b0;
        end
        t = 0;
        while (results == r0 && t < 500) begin @(negedge clk); t++; end
        if (results == r0) chk("turn_timeout", 0, 1);
        chk("lit_direction", direction, lit_dir);
        chk("lit_extra", extra_move, lit_ex);
        chk("lit_nomove", no_move, lit_nm);
        chk("latched_color", color, col);
        chk("latched_x", cur_x, x);
        chk("latched_y", cur_y, y);
        chk("latched_w", width, w);
        chk("latched_l", length, l);
        repeat (4) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int t;
        clr_cfg();
        exp_goal = 0; exp_dir = 0; exp_extra = 0; exp_nomove = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_direction", direction, 0);
        chk("reset_nomove", no_move, 0);
        chk("reset_color", color, 0);
        chk("reset_x", cur_x, 0);
        chk("reset_eval_dir", eval_dir, 0);

        // goal shortcuts, both colours, all three goal columns
        turn(0, 3, 10, 8, 10, 1, 0, 0, 0);
        turn(0, 4, 10, 8, 10, 0, 0, 0, 0);
        turn(0, 5, 10, 8, 10, 7, 0, 0, 0);
        turn(1, 3, 0, 8, 10, 3, 0, 0, 0);
        turn(1, 4, 0, 8, 10, 4, 0, 0, 0);
        turn(1, 5, 0, 8, 10, 5, 0, 0, 0);

        // one column off the goal mouth: full evaluation
        clr_cfg();
        for (int i = 0; i < 8; i++) sc[i] = i;
        ex[7] = 1;
        turn(0, 6, 10, 8, 10, 7, 1, 0, 0);

        // red argmax with tie between 1 and 3; repeated my_turn mid-turn
        clr_cfg();
        sc = '{5, 9, 2, 9, 1, 0, 3, 4};
        ex[3] = 1;
        turn(1, 2, 5, 8, 10, 3, 1, 0, 1);

        // every direction refused
        clr_cfg();
        for (int i = 0; i < 8; i++) begin beh[i] = (i % 2) ? 1 : 3; sc[i] = 50; ex[i] = 1; end
        turn(1, 2, 5, 8, 10, 1, 0, 1, 0);

        // timeout on 2 (silent) and 4 (answers exactly at the limit)
        clr_cfg();
        sc = '{10, 20, 0, 30, 240, 5, 15, 25};
        beh[2] = 2; dly[4] = 4; ex[3] = 1;
        turn(0, 1, 5, 8, 10, 3, 1, 0, 0);

        // done and noperm together on the top-scoring blue direction
        clr_cfg();
        sc = '{255, 50, 40, 10, 10, 10, 10, 50};
        beh[0] = 3; ex[7] = 1;
        turn(0, 1, 5, 8, 10, 1, 0, 0, 0);

        // unsigned compare: 128 beats 127 despite lower priority
        clr_cfg();
        sc[4] = 127; sc[1] = 128; ex[1] = 1;
        turn(1, 2, 5, 8, 10, 1, 1, 0, 0);

        // ties resolved by priority slot
        clr_cfg();
        sc = '{100, 10, 200, 50, 60, 200, 90, 1};
        turn(1, 2, 5, 8, 10, 5, 0, 0, 0);
        clr_cfg();
        sc = '{20, 30, 40, 90, 10, 80, 90, 50};
        turn(0, 2, 5, 8, 10, 6, 0, 0, 0);

        // single legal direction with score 0
        clr_cfg();
        for (int i = 1; i < 8; i++) beh[i] = 1;
        turn(1, 2, 5, 8, 10, 0, 0, 0, 0);

        // reset in the middle of an evaluation
        clr_cfg();
        for (int i = 0; i < 8; i++) begin sc[i] = 200; ex[i] = 1; end
        cfg_color = 1; cfg_x = 2; cfg_y = 5; cfg_w = 8; cfg_l = 10;
        model();
        @(negedge clk);
        color_in = 1'b1; cur_x_in = 8'd2; cur_y_in = 8'd5; width_in = 8'd8; length_in = 8'd10;
        my_turn = 1'b1;
        @(negedge clk);
        my_turn = 1'b0;
        t = 0;
        while (!(eval_start && eval_dir == 3'd3) && t < 300) begin @(negedge clk); t++; end
        chk("reach_eval3", eval_start, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_eval_start", eval_start, 0);
        chk("midrst_idle", idle, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle", idle, 1);
        chk("post_rst_direction", direction, 0);
        chk("post_rst_extra", extra_move, 0);

        // fresh turn after reset, no leakage from the aborted one
        clr_cfg();
        sc = '{1, 2, 3, 4, 5, 6, 7, 8};
        turn(1, 2, 5, 8, 10, 7, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
